// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a two-entry skid buffer so upstream ready is a flop.
// Optional statistics counters are enabled by defining PIPE_STAGE_STATS_EN.
module pipe_stage_skid #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 6,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CTRL_W-1:0] out_ctrl_o
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [CNT_W-1:0]  stall_count_o,
    output logic [CNT_W-1:0]  flush_count_o
`endif
);

    if (DATA_W < 1 || CTRL_W < 1 || CNT_W < 1) begin : g_param_check
        $error("pipe_stage_skid: DATA_W, CTRL_W and CNT_W must be positive");
    end

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_e;

    state_e            state_q;
    logic              out_valid_q;
    logic              in_ready_q;
    logic [DATA_W-1:0] out_data_q;
    logic [CTRL_W-1:0] out_ctrl_q;
    logic [DATA_W-1:0] skid_data_q;
    logic [CTRL_W-1:0] skid_ctrl_q;

    // Flush outranks every handshake; anything offered in a flush cycle is dropped.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            out_data_q  <= '0;
            out_ctrl_q  <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
        end else if (flush_i) begin
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            out_data_q  <= '0;
            out_ctrl_q  <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_valid_i) begin
                        state_q     <= FULL;
                        out_valid_q <= 1'b1;
                        out_data_q  <= in_data_i;
                        out_ctrl_q  <= in_ctrl_i;
                    end
                end
                FULL: begin
                    if (in_valid_i && out_ready_i) begin
                        out_data_q <= in_data_i;
                        out_ctrl_q <= in_ctrl_i;
                    end else if (in_valid_i) begin
                        state_q     <= SKID;
                        in_ready_q  <= 1'b0;
                        skid_data_q <= in_data_i;
                        skid_ctrl_q <= in_ctrl_i;
                    end else if (out_ready_i) begin
                        // Drained: data keeps its last value, control must not leak.
                        state_q     <= EMPTY;
                        out_valid_q <= 1'b0;
                        out_ctrl_q  <= '0;
                    end
                end
                SKID: begin
                    if (out_ready_i) begin
                        state_q    <= FULL;
                        in_ready_q <= 1'b1;
                        out_data_q <= skid_data_q;
                        out_ctrl_q <= skid_ctrl_q;
                    end
                end
                default: begin
                    state_q     <= EMPTY;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    out_ctrl_q  <= '0;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_ctrl_o  = out_ctrl_q;

`ifdef PIPE_STAGE_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Both counters saturate at all-ones rather than wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (out_valid_q && !out_ready_i && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush_i && (state_q != EMPTY) && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_count_o = stall_cnt_q;
    assign flush_count_o = flush_cnt_q;
`endif

endmodule
